// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- multi-cycle datapath ALU with a START/BUSY/DONE handshake.
//
// Single-cycle ops (FWD, ADD, AND, OR, SUB) and illegal codes complete on the
// capture edge. Shifts (SLL, SRL, SRA, ROR) move one bit per cycle. The
// optional MUL runs DATA_W shift-add steps.
//
// Handshake: START is sampled on a rising CLK edge only while BUSY=0; OP,
// DATA1 and DATA2 are captured on that same edge. While BUSY=1 every input
// is ignored, and a START seen then is dropped rather than queued. DONE
// pulses for one cycle when RESULT/ZERO/ILLEGAL update. BUSY is already low
// in that cycle, so a new START is accepted on the next edge.
//
// Optional feature macro: SEQ_ALU_MUL_EN
//   defined   -> OP 9 is an unsigned multiply (low DATA_W bits kept)
//   undefined -> no multiplier; OP 9 completes at once as an illegal op
//
// Ports:
//   CLK      in   rising-edge clock
//   RESET    in   synchronous, active-high reset
//   START    in   operation request
//   OP       in   [3:0] operation code
//   DATA1    in   [DATA_W-1:0] first operand
//   DATA2    in   [DATA_W-1:0] second operand / shift amount
//   BUSY     out  multi-cycle operation in progress (FSM is in RUN)
//   DONE     out  one-cycle completion pulse
//   RESULT   out  [DATA_W-1:0] registered result
//   ZERO     out  registered RESULT==0
//   ILLEGAL  out  last completed OP was unsupported
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [3:0]        OP,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO,
    output logic              ILLEGAL
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_FWD = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif

    // DATA_W widened by one bit so it can be compared against DATA2.
    localparam logic [DATA_W:0] W_EXT = (DATA_W + 1)'(DATA_W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;        // shifted operand / multiplicand
`ifdef SEQ_ALU_MUL_EN
    logic [DATA_W-1:0]   b_q, b_d;        // multiplier, consumed LSB first
    logic [DATA_W-1:0]   acc_q, acc_d;    // low half of the product
`endif
    logic                done_q, done_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;

    // Shift counts derived from DATA2 at capture time.
    logic [CNT_W-1:0]    n_lin;
    logic [CNT_W-1:0]    n_rot;

    // Completion request raised by either FSM state.
    logic                fin;
    logic [DATA_W-1:0]   fin_val;
    logic                fin_ill;

    // Linear shifts saturate at DATA_W; rotates wrap modulo DATA_W.
    assign n_lin = ({1'b0, DATA2} >= W_EXT) ? CNT_W'(DATA_W) : CNT_W'(DATA2);
    assign n_rot = CNT_W'(DATA2 % DATA_W);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
`ifdef SEQ_ALU_MUL_EN
        b_d       = b_q;
        acc_d     = acc_q;
`endif
        done_d    = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        fin       = 1'b0;
        fin_val   = '0;
        fin_ill   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d = OP;
                    a_d  = DATA1;
`ifdef SEQ_ALU_MUL_EN
                    b_d   = DATA2;
                    acc_d = '0;
`endif
                    case (OP)
                        OP_FWD: begin fin = 1'b1; fin_val = DATA2;          end
                        OP_ADD: begin fin = 1'b1; fin_val = DATA1 + DATA2;  end
                        OP_AND: begin fin = 1'b1; fin_val = DATA1 & DATA2;  end
                        OP_OR:  begin fin = 1'b1; fin_val = DATA1 | DATA2;  end
                        OP_SUB: begin fin = 1'b1; fin_val = DATA1 - DATA2;  end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (n_lin == '0) begin
                                fin     = 1'b1;
                                fin_val = DATA1;
                            end else begin
                                cnt_d   = n_lin;
                                state_d = S_RUN;
                            end
                        end
                        OP_ROR: begin
                            if (n_rot == '0) begin
                                fin     = 1'b1;
                                fin_val = DATA1;
                            end else begin
                                cnt_d   = n_rot;
                                state_d = S_RUN;
                            end
                        end
`ifdef SEQ_ALU_MUL_EN
                        OP_MUL: begin
                            cnt_d   = CNT_W'(DATA_W);
                            state_d = S_RUN;
                        end
`endif
                        default: begin
                            // Unsupported code: zero result flagged illegal.
                            fin     = 1'b1;
                            fin_ill = 1'b1;
                        end
                    endcase
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                case (op_q)
                    OP_SLL: a_d = {a_q[DATA_W-2:0], 1'b0};
                    OP_SRL: a_d = {1'b0, a_q[DATA_W-1:1]};
                    OP_SRA: a_d = {a_q[DATA_W-1], a_q[DATA_W-1:1]};
                    OP_ROR: a_d = {a_q[0], a_q[DATA_W-1:1]};
`ifdef SEQ_ALU_MUL_EN
                    OP_MUL: begin
                        // Bits of the product above DATA_W-1 never reach
                        // RESULT, so a DATA_W-wide accumulator suffices.
                        acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
                        a_d   = {a_q[DATA_W-2:0], 1'b0};
                        b_d   = {1'b0, b_q[DATA_W-1:1]};
                    end
`endif
                    default: a_d = a_q;
                endcase

                // The edge that takes the counter from 1 to 0 completes.
                if (cnt_q == CNT_W'(1)) begin
                    fin     = 1'b1;
                    fin_val = a_d;
`ifdef SEQ_ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        fin_val = acc_d;
                    end
`endif
                    state_d = S_IDLE;
                end
            end
        endcase

        if (fin) begin
            done_d    = 1'b1;
            result_d  = fin_val;
            zero_d    = (fin_val == '0);
            illegal_d = fin_ill;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            op_q      <= OP_FWD;
            cnt_q     <= '0;
            a_q       <= '0;
`ifdef SEQ_ALU_MUL_EN
            b_q       <= '0;
            acc_q     <= '0;
`endif
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
`ifdef SEQ_ALU_MUL_EN
            b_q       <= b_d;
            acc_q     <= acc_d;
`endif
            done_q    <= done_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign BUSY    = (state_q == S_RUN);
    assign DONE    = done_q;
    assign RESULT  = result_q;
    assign ZERO    = zero_q;
    assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (DATA_W=8). Expected results are pushed
// when an operation is driven and popped when DONE is observed.
module tb_seq_alu;
  localparam int DW = 8;
  localparam int W  = DW + 2;   // {illegal, zero, result}

  localparam logic [3:0] OP_FWD = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  logic          CLK;
  logic          RESET;
  logic          START;
  logic [3:0]    OP;
  logic [DW-1:0] DATA1;
  logic [DW-1:0] DATA2;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] RESULT;
  logic          ZERO;
  logic          ILLEGAL;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  seq_alu #(.DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .ZERO(ZERO), .ILLEGAL(ILLEGAL)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic signed [DW-1:0] sa;
    logic [2*DW-1:0] dbl;
    logic ill;
    r = '0;
    ill = 1'b0;
    sa = a;
    dbl = {a, a} >> (b % DW);
    case (op)
      OP_FWD: r = b;
      OP_ADD: r = a + b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SUB: r = a - b;
      OP_SLL: r = (b >= DW) ? '0 : (a << b);
      OP_SRL: r = (b >= DW) ? '0 : (a >> b);
      OP_SRA: r = (b >= DW) ? {DW{a[DW-1]}} : DW'(sa >>> b);
      OP_ROR: r = dbl[DW-1:0];
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: r = DW'(a * b);
`endif
      default: ill = 1'b1;
    endcase
    return {ill, (r == '0), r};
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [DW-1:0] b);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: return (b >= DW) ? DW : int'(b);
      OP_ROR: return int'(b % DW);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: return DW;
`endif
      default: return 0;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin : mon
    logic [W-1:0] e;
    if (DONE) begin
      check("done_has_expectation", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'(RESULT), 32'(e[DW-1:0]));
        check("zero", 32'(ZERO), 32'(e[DW]));
        check("illegal", 32'(ILLEGAL), 32'(e[DW+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the capture edge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input bit push);
    OP = op;
    DATA1 = d1;
    DATA2 = d2;
    START = 1'b1;
    if (push) exp_q.push_back(model(op, d1, d2));
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Counts edges after capture until DONE; optionally toggles inputs while busy.
  task automatic wait_done(input int exp_lat, input bit noise);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      check("busy_while_running", 32'(BUSY), 32'd1);
      k++;
      if (noise) begin
        START = 1'($urandom_range(0, 1));
        OP    = 4'($urandom_range(0, 15));
        DATA1 = DW'($urandom_range(0, 255));
        DATA2 = DW'($urandom_range(0, 255));
      end
    end
    START = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(k), 32'(exp_lat));
    check("busy_at_done", 32'(BUSY), 32'd0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input bit noise);
    issue(op, d1, d2, 1'b1);
    wait_done(lat_of(op, d2), noise);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    START = 1'b0;
    OP = '0;
    DATA1 = '0;
    DATA2 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    check("rst_zero", 32'(ZERO), 32'd1);
    check("rst_illegal", 32'(ILLEGAL), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Single-cycle op and one-cycle DONE pulse.
    run_op(OP_ADD, 8'h7F, 8'h01, 1'b0);
    @(negedge CLK);
    check("done_pulse_width", 32'(DONE), 32'd0);

    // Back-to-back single-cycle ops on consecutive edges.
    run_op(OP_SUB, 8'h05, 8'h05, 1'b0);
    run_op(OP_FWD, 8'h00, 8'h3C, 1'b0);
    run_op(OP_AND, 8'hF0, 8'h3C, 1'b0);
    run_op(OP_OR,  8'hF0, 8'h0C, 1'b0);

    // Iterative shifts, saturation and wrap boundaries.
    run_op(OP_SRA, 8'h90, 8'd3, 1'b0);
    run_op(OP_SLL, 8'hFF, 8'd9, 1'b0);
    run_op(OP_SRA, 8'h80, 8'd200, 1'b0);
    run_op(OP_SRL, 8'hA5, 8'd7, 1'b1);
    run_op(OP_ROR, 8'h81, 8'd9, 1'b1);
    run_op(OP_SLL, 8'h3C, 8'd0, 1'b0);
    run_op(OP_ROR, 8'h5A, 8'd16, 1'b0);
    run_op(OP_ROR, 8'h12, 8'd7, 1'b1);

    // Multiply (or illegal OP 9) and a plainly illegal code.
    run_op(OP_MUL, 8'h13, 8'h0D, 1'b1);
    run_op(4'hF, 8'h12, 8'h34, 1'b0);
    run_op(OP_ADD, 8'h01, 8'h01, 1'b0);

    // Random mix, back to back.
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), DW'($urandom_range(0, 255)),
             DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // RESET wins over a coincident START.
    RESET = 1'b1;
    START = 1'b1;
    OP = OP_ADD;
    DATA1 = 8'h01;
    DATA2 = 8'h01;
    @(posedge CLK);
    #1 RESET = 1'b0;
    START = 1'b0;
    @(negedge CLK);
    check("rst_start_busy", 32'(BUSY), 32'd0);
    check("rst_start_result", 32'(RESULT), 32'd0);
    check("rst_start_zero", 32'(ZERO), 32'd1);

    // RESET at edge t+4 of a long operation aborts it without DONE.
`ifdef SEQ_ALU_MUL_EN
    issue(OP_MUL, 8'h13, 8'h0D, 1'b0);
`else
    issue(OP_SRL, 8'hFF, 8'd8, 1'b0);
`endif
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_result", 32'(RESULT), 32'd0);
    check("abort_zero", 32'(ZERO), 32'd1);
    check("abort_illegal", 32'(ILLEGAL), 32'd0);
    repeat (10) @(negedge CLK);
    check("abort_no_late_done", 32'(DONE), 32'd0);
    run_op(OP_ADD, 8'h02, 8'h03, 1'b0);

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the 8-bit datapath ALU. It keeps the single-cycle forward, add, and, or and subtract operations and adds iterative shifts, rotate and an optional shift-add multiplier. A START/BUSY/DONE handshake lets the control unit stall the PC while a long operation completes. It sits between the operand muxes and the register-file write port.

## Interface
- DATA_W, default 8: operand and result width; must be at least 2; shift amount is taken from DATA2.
- CLK  in  1  rising-edge clock.
- RESET  in  1  reset, synchronous, active-high; clock CLK.
- START  in  1  request; sampled on CLK only when BUSY=0.
- OP  in  4  operation code, captured with START.
- DATA1  in  DATA_W  first operand, captured with START.
- DATA2  in  DATA_W  second operand or shift amount, captured with START.
- BUSY  out  1  multi-cycle operation in progress.
- DONE  out  1  one-cycle pulse when RESULT is updated.
- RESULT  out  DATA_W  registered result; holds until the next completion.
- ZERO  out  1  registered (RESULT==0).
- ILLEGAL  out  1  last completed OP was unsupported.

## Operation
- OP codes:
  - 0 FWD: DATA2.
  - 1 ADD: DATA1+DATA2 mod 2^DATA_W.
  - 2 AND.
  - 3 OR.
  - 4 SUB: DATA1-DATA2 mod 2^DATA_W.
  - 5 SLL.
  - 6 SRL.
  - 7 SRA.
  - 8 ROR.
  - 9 MUL: low DATA_W bits of the unsigned product.
  - 10-15 illegal.
- Shift count n:
  - SLL/SRL/SRA: n = min(DATA2, DATA_W), with DATA2 treated as unsigned.
  - ROR: n = DATA2 mod DATA_W.
- Shifts are applied one bit per cycle.
- Results for n = DATA_W: SLL and SRL give 0; SRA gives all bits equal to the sign of DATA1.
- MUL runs DATA_W shift-add iterations on internal accumulators of width 2*DATA_W or less. Only the low DATA_W bits go to RESULT.
- Two-state FSM, IDLE and RUN:
  - IDLE, START=1, single-cycle OP, illegal OP, or shift with n=0: complete at the capture edge and stay in IDLE.
  - IDLE, START=1, shift with n≥1 or MUL: load operands and counter (n, or DATA_W for MUL), then go to RUN.
  - RUN: decrement the counter on each edge. The edge that brings it to 0 writes RESULT, pulses DONE and returns to IDLE.
- Completion always updates RESULT, ZERO and ILLEGAL together. For an illegal OP: RESULT=0, ZERO=1, ILLEGAL=1.
- Inputs are ignored while BUSY=1. START during RUN is dropped, not queued.
- Reset values: BUSY=0, DONE=0, RESULT=0, ZERO=1, ILLEGAL=0, FSM=IDLE.

## Timing
- Capture edge t is the edge with START=1 and BUSY=0.
- Single-cycle ops, illegal ops, n=0: DONE=1 and the new RESULT are visible after edge t. BUSY stays 0.
- Shift, n≥1: BUSY=1 after edge t. DONE=1, BUSY=0 and the new RESULT after edge t+n.
- MUL: same as shift with n=DATA_W.
- Back-to-back: in the cycle DONE=1, BUSY=0, so START is accepted at the next edge with no bubble.
- DONE is high for exactly one cycle per accepted START.
- RESET during RUN aborts at that edge: outputs take reset values, no DONE pulse, partial result is discarded.
- RESET has priority over a coincident START.

## Configuration
- SEQ_ALU_MUL_EN:
  - Defined: OP 9 is MUL as above.
  - Undefined: multiplier logic is absent. OP 9 is treated as illegal and completes single-cycle with RESULT=0 and ILLEGAL=1.

## Test plan
- DATA_W=8, ADD 0x7F+0x01 -> after edge t: RESULT=0x80, DONE=1 for one cycle, ZERO=0, BUSY never 1.
- SUB 0x05-0x05, then immediate FWD 0x3C -> RESULT 0x00/ZERO=1, then 0x3C/ZERO=0 on consecutive edges.
- SRA 0x90 by 3 -> BUSY high 3 cycles, RESULT=0xF2 after edge t+3. SLL 0xFF by 9 -> RESULT=0x00 after edge t+8.
- ROR 0x81 by 9 (n=1) -> RESULT=0xC0 after edge t+1. Changes on START, DATA1 and OP during BUSY have no effect.
- MUL 0x13×0x0D with the macro -> RESULT=0xF7 after edge t+8. Without the macro -> RESULT=0x00, ILLEGAL=1 after edge t. OP 0xF -> ILLEGAL=1.
- RESET at edge t+4 of a MUL -> BUSY=0, DONE=0, RESULT=0, ZERO=1, no DONE pulse. The next ADD 2+3 -> 0x05.
